// File: rtl/monolith_bricks_seq.sv
// Monolith-31 Bricks layer: y[0]=x[0], y[i]=x[i]+x[i-1]^2 mod 2^31-1,
// one element per cycle through a single shared squarer.
// Ports: clk, reset (async, active-low), in_valid/in_ready/state_in
// (from Bars), out_valid/out_ready/state_out (to Concrete).
// Option: MONOLITH_BRICKS_PIPE_MUL_EN registers the 62-bit product
// before reduction (one extra cycle of latency, same results).
module monolith_bricks_seq #(
  parameter int WORD_WIDTH = 31,
  parameter int STATE_SIZE = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [0:STATE_SIZE-1][WORD_WIDTH-1:0] state_in,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [0:STATE_SIZE-1][WORD_WIDTH-1:0] state_out
);

  localparam int W  = WORD_WIDTH;
  localparam int IW = $clog2(STATE_SIZE);
  localparam logic [W-1:0]  P    = {W{1'b1}};
  localparam logic [IW-1:0] LAST = IW'(STATE_SIZE - 1);
  localparam logic [IW-1:0] ONE  = IW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } st_t;

  // The all-ones word is the second encoding of zero in M31.
  function automatic logic [W-1:0] norm(
    input logic [W-1:0] v
  );
    return (v == P) ? '0 : v;
  endfunction

  // 2^31 == 1 mod p, so fold the high half onto the low half.
  // Operands are < p, so one conditional subtract is enough.
  function automatic logic [W-1:0] mod_red(
    input logic [2*W-1:0] sq
  );
    logic [W:0] r;
    r = {1'b0, sq[2*W-1:W]} + {1'b0, sq[W-1:0]};
    if (r >= {1'b0, P})
      r = r - {1'b0, P};
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_add(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P})
      s = s - {1'b0, P};
    return s[W-1:0];
  endfunction

  st_t state_q;
  st_t state_d;

  logic [0:STATE_SIZE-1][W-1:0] x_q;
  logic [0:STATE_SIZE-1][W-1:0] y_q;
  logic [IW-1:0]                idx_q;
  logic                         out_valid_q;

  logic           accept;
  logic           issue;
  logic           wr_en;
  logic [IW-1:0]  wr_idx;
  logic [W-1:0]   wr_val;
  logic           last_wr;
  logic [W-1:0]   sq_op;
  logic [2*W-1:0] prod;

  assign accept = in_valid && in_ready;

  // x is stored already normalised, so every operand is < p.
  assign sq_op = x_q[idx_q - ONE];
  assign prod  = {{W{1'b0}}, sq_op} * {{W{1'b0}}, sq_op};

`ifdef MONOLITH_BRICKS_PIPE_MUL_EN
  logic           iss_q;
  logic           pv_q;
  logic [2*W-1:0] prod_q;
  logic [W-1:0]   addend_q;
  logic [IW-1:0]  widx_q;

  // Squares issue for idx 1..N-1; writes retire one cycle later.
  assign issue  = (state_q == CALC) && iss_q;
  assign wr_en  = pv_q;
  assign wr_idx = widx_q;
  assign wr_val = mod_add(addend_q, mod_red(prod_q));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iss_q    <= 1'b0;
      pv_q     <= 1'b0;
      prod_q   <= '0;
      addend_q <= '0;
      widx_q   <= '0;
    end else begin
      pv_q <= issue;
      if (issue) begin
        prod_q   <= prod;
        addend_q <= x_q[idx_q];
        widx_q   <= idx_q;
      end
      if (accept)
        iss_q <= 1'b1;
      else if (issue && idx_q == LAST)
        iss_q <= 1'b0;
    end
  end
`else
  assign issue  = (state_q == CALC);
  assign wr_en  = issue;
  assign wr_idx = idx_q;
  assign wr_val = mod_add(x_q[idx_q], mod_red(prod));
`endif

  assign last_wr = wr_en && (wr_idx == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: if (last_wr) state_d = DONE;
      DONE: if (out_valid_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = out_valid_q;
    state_out = y_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q         <= '0;
      y_q         <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < STATE_SIZE; i++)
          x_q[i] <= norm(state_in[i]);
        y_q[0] <= norm(state_in[0]);
        idx_q  <= ONE;
      end else if (issue) begin
        idx_q <= idx_q + ONE;
      end
      if (wr_en)
        y_q[wr_idx] <= wr_val;
      // Result is presented on the cycle after the last write lands.
      if (state_q == DONE && !out_valid_q)
        out_valid_q <= 1'b1;
      else if (out_valid_q && out_ready)
        out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_monolith_bricks_seq.sv
// Bench for monolith_bricks_seq: vector table plus hand-written
// backpressure, reset-abort and back-to-back sequences.
module tb_monolith_bricks_seq;

`ifdef MONOLITH_BRICKS_PIPE_MUL_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 16;
`endif
  localparam int N = 16;
  localparam logic [30:0] P = 31'h7FFFFFFF;
  localparam logic [30:0] PM1 = 31'h7FFFFFFE;

  typedef logic [0:N-1][30:0] st_t;

  typedef struct {
    string name;
    st_t   x;
    st_t   y;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  st_t  state_in = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  st_t  state_out;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t vecs[6];

  always #5 clk = ~clk;

  monolith_bricks_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out)
  );

  task automatic check(
    input string        name,
    input logic [495:0] got,
    input logic [495:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_ready"}, in_ready, 1);
  endtask

  task automatic wait_valid(output int t);
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
  endtask

  task automatic send(input st_t x);
    in_valid = 1'b1;
    state_in = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int  t;
    logic ok;
    wait_ready(v.name);
    send(v.x);
    wait_valid(t);
    check({v.name, "_lat"}, t, LAT);
    check({v.name, "_y"}, state_out, v.y);
    ok = 1'b1;
    for (int i = 0; i < N; i++)
      if (state_out[i] == P) ok = 1'b0;
    check({v.name, "_range"}, ok, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({v.name, "_rel"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int   t;
    int   ta;
    int   tin;
    int   tacc;
    int   tb;
    logic ok;

    vecs[0].name = "seq";
    for (int i = 0; i < N; i++)
      vecs[0].x[i] = 31'(i + 1);
    vecs[0].y = {31'd1, 31'd3, 31'd7, 31'd13, 31'd21, 31'd31,
                 31'd43, 31'd57, 31'd73, 31'd91, 31'd111,
                 31'd133, 31'd157, 31'd183, 31'd211, 31'd241};

    vecs[1].name = "pm1_sq";
    vecs[1].x = '0;
    vecs[1].x[0] = PM1;
    vecs[1].y = '0;
    vecs[1].y[0] = PM1;
    vecs[1].y[1] = 31'd1;

    vecs[2].name = "sum_wrap";
    vecs[2].x = '0;
    vecs[2].x[0] = 31'd1;
    vecs[2].x[1] = PM1;
    vecs[2].y = '0;
    vecs[2].y[0] = 31'd1;
    vecs[2].y[1] = 31'd0;
    vecs[2].y[2] = 31'd1;

    vecs[3].name = "fold";
    vecs[3].x = '0;
    vecs[3].x[0] = 31'h00010000;
    vecs[3].x[1] = 31'd5;
    vecs[3].y = '0;
    vecs[3].y[0] = 31'h00010000;
    vecs[3].y[1] = 31'd7;
    vecs[3].y[2] = 31'd25;

    vecs[4].name = "norm";
    vecs[4].x = '0;
    vecs[4].x[0] = P;
    vecs[4].x[1] = 31'd9;
    vecs[4].y = '0;
    vecs[4].y[1] = 31'd9;
    vecs[4].y[2] = 31'd81;

    vecs[5].name = "all_pm1";
    for (int i = 0; i < N; i++)
      vecs[5].x[i] = PM1;
    vecs[5].y = '0;
    vecs[5].y[0] = PM1;

    #3;
    check("rst_ov", out_valid, 0);
    check("rst_ir", in_ready, 1);
    check("rst_y", state_out, '0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++)
      run_vec(vecs[v]);

    // Backpressure: hold the result for 20 cycles.
    wait_ready("bp");
    send(vecs[0].x);
    wait_valid(t);
    check("bp_lat", t, LAT);
    ok = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (state_out !== vecs[0].y || in_ready !== 1'b0 ||
          out_valid !== 1'b1)
        ok = 1'b0;
    end
    check("bp_hold", ok, 1);
    check("bp_y", state_out, vecs[0].y);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_rel", {out_valid, in_ready}, 2'b01);

    // Reset asserted mid-computation at idx 7.
    wait_ready("ab");
    send(vecs[0].x);
    repeat (6) @(posedge clk);
    #2;
    check("ab_busy", in_ready, 0);
    reset = 1'b0;
    #1;
    check("ab_ov", out_valid, 0);
    check("ab_ir", in_ready, 1);
    check("ab_y", state_out, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    vecs[3].name = "after_rst";
    run_vec(vecs[3]);

    // Back-to-back with in_valid and out_ready held high.
    wait_ready("b2b");
    out_ready = 1'b1;
    in_valid  = 1'b1;
    state_in  = vecs[0].x;
    @(posedge clk); #1;
    state_in = vecs[5].x;
    ta = -1;
    tin = -1;
    tacc = -1;
    tb = -1;
    t = 0;
    while (tb < 0 && t < 120) begin
      @(posedge clk); #1;
      t++;
      if (tacc >= 0 && in_valid) in_valid = 1'b0;
      if (out_valid && ta < 0) begin
        ta = t;
        check("b2b_ya", state_out, vecs[0].y);
        check("b2b_irdone", in_ready, 0);
      end else if (out_valid && tacc >= 0) begin
        tb = t;
        check("b2b_yb", state_out, vecs[5].y);
      end
      if (ta >= 0 && in_ready && tin < 0) begin
        tin = t;
        tacc = t + 1;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_ta", ta, LAT);
    check("b2b_tin", tin, LAT + 1);
    check("b2b_tb", tb, 2 * LAT + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
